// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, response and memory bus signals for the two-port memory arbiter
//   slave  : arbiter side (takes CPU/DMA requests and memory responses, drives acks, rdata and memory strobes)
//   master : environment side (CPU/DMA requesters and the physical memory)
interface mem_arbiter_if;
  logic        cpu_read, cpu_write, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_read, dma_write, dma_ack;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        err;
  logic        mem_read, mem_write, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        owner;
  logic [1:0]  arb_state;
  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  dma_read, dma_write, dma_addr, dma_wdata,
    input  mem_rdata, mem_ack,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack, err,
    output mem_read, mem_write, mem_addr, mem_wdata, owner, arb_state
  );
  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output dma_read, dma_write, dma_addr, dma_wdata,
    output mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack, err,
    input  mem_read, mem_write, mem_addr, mem_wdata, owner, arb_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory bus between a CPU port and a DMA port
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : mem_arbiter_if.slave (CPU/DMA request ports, memory bus, err, owner, arb_state)
//   TIMEOUT : BUSY cycles without mem_ack before an error completion (0 disables)
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic         clock,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam logic [7:0] TO = TIMEOUT[7:0];
  state_t      r_state;
  logic        r_last;
  logic [7:0]  r_cnt;
  logic        w_cpu_req, w_dma_req, w_grant_dma, w_wr;
  logic [7:0]  w_cnt_nxt;
  logic        w_timeout, w_fin;
  logic [15:0] w_rdata;
  assign w_cpu_req   = bus.cpu_read | bus.cpu_write;
  assign w_dma_req   = bus.dma_read | bus.dma_write;
  // on a tie the port that was not granted last wins
  assign w_grant_dma = w_dma_req & (~w_cpu_req | ~r_last);
  assign w_wr        = w_grant_dma ? bus.dma_write : bus.cpu_write;
  assign w_cnt_nxt   = r_cnt + 8'd1;
  // mem_ack has priority, so an ack on the timeout cycle is a normal completion
  assign w_timeout   = (TIMEOUT != 0) && !bus.mem_ack && (w_cnt_nxt == TO);
  assign w_fin       = bus.mem_ack | w_timeout;
  assign w_rdata     = bus.mem_ack ? bus.mem_rdata : 16'hFFFF;
  assign bus.arb_state = r_state;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.err       <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
      bus.owner     <= 1'b0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      bus.err     <= 1'b0;
      case (r_state)
        IDLE: if (w_cpu_req | w_dma_req) begin
          bus.owner     <= w_grant_dma;
          r_last        <= w_grant_dma;
          bus.mem_addr  <= w_grant_dma ? bus.dma_addr : bus.cpu_addr;
          bus.mem_wdata <= w_grant_dma ? bus.dma_wdata : bus.cpu_wdata;
          bus.mem_write <= w_wr;
          bus.mem_read  <= ~w_wr;
          r_cnt         <= '0;
          r_state       <= BUSY;
        end
        BUSY: begin
          r_cnt <= w_cnt_nxt;
          if (w_fin) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (bus.mem_read && bus.owner) bus.dma_rdata <= w_rdata;
            if (bus.mem_read && !bus.owner) bus.cpu_rdata <= w_rdata;
            bus.dma_ack <= bus.owner;
            bus.cpu_ack <= ~bus.owner;
            bus.err     <= w_timeout;
            r_state     <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
